// File: rtl/mips_multicycle_core_if.sv
// Unified word-memory port: one req/ack transfer at a time, shared by fetch and data.
interface mips_multicycle_core_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core; one req/ack memory port for fetch and load/store.
// CPI with zero-wait memory: R/addi/sw 4, lw 5, beq/j 3; hold freezes everything and withdraws the request.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   hold,
   mips_multicycle_core_if.master mem,
   output logic [31:0]            pc,
   output logic [2:0]             state,
   output logic                   halted,
   output logic                   retire
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] alu_q;
   logic [31:0] mdr_q;
   logic [31:0] rf_q [32];

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic [31:0] sext_imm;

   logic        is_r;
   logic        r_ok;
   logic        is_addi;
   logic        is_lw;
   logic        is_sw;
   logic        is_beq;
   logic        is_j;
   logic        legal;

   logic [31:0] alu_d;
   logic [31:0] br_pc_d;
   logic [31:0] jmp_pc_d;
   logic [4:0]  wb_dst_d;
   logic [31:0] wb_dat_d;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        req_c;

   assign op       = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign imm16    = ir_q[15:0];
   assign imm26    = ir_q[25:0];
   assign sext_imm = {{16{imm16[15]}}, imm16};

   always_comb begin
      is_r    = (op == OP_RTYPE);
      is_addi = (op == OP_ADDI);
      is_lw   = (op == OP_LW);
      is_sw   = (op == OP_SW);
      is_beq  = (op == OP_BEQ);
      is_j    = (op == OP_J);
      r_ok    = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                (funct == FN_OR)  || (funct == FN_SLT);
      legal   = (is_r && r_ok) || is_addi || is_lw || is_sw || is_beq || is_j;
   end

   // Address generation and addi share the immediate adder path.
   always_comb begin
      alu_d = a_q + sext_imm;
      if (is_r) begin
         case (funct)
            FN_ADD:  alu_d = a_q + b_q;
            FN_SUB:  alu_d = a_q - b_q;
            FN_AND:  alu_d = a_q & b_q;
            FN_OR:   alu_d = a_q | b_q;
            FN_SLT:  alu_d = {31'd0, ($signed(a_q) < $signed(b_q))};
            default: alu_d = a_q + b_q;
         endcase
      end
   end

   assign br_pc_d  = pc_q + {sext_imm[29:0], 2'b00};
   assign jmp_pc_d = {pc_q[31:28], imm26, 2'b00};
   assign wb_dst_d = is_r ? rd : rt;
   assign wb_dat_d = is_lw ? mdr_q : alu_q;
   assign rs_val   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
   assign rt_val   = (rt == 5'd0) ? 32'd0 : rf_q[rt];

   assign req_c = ((state_q == S_FETCH) || (state_q == S_MEM)) && !hold && !reset;

   // Bus fields are zeroed whenever no request is outstanding.
   always_comb begin
      mem.mem_req   = req_c;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = 32'd0;
      mem.mem_wdata = 32'd0;
      if (req_c) begin
         if (state_q == S_FETCH) begin
            mem.mem_addr = {pc_q[31:2], 2'b00};
         end else begin
            mem.mem_addr  = {alu_q[31:2], 2'b00};
            mem.mem_we    = is_sw;
            mem.mem_wdata = is_sw ? b_q : 32'd0;
         end
      end
   end

   always_comb begin
      retire = 1'b0;
      if (!hold && !reset) begin
         case (state_q)
            S_DECODE: retire = !legal && !TRAP_ON_ILLEGAL;
            S_EXEC:   retire = is_beq || is_j;
            S_MEM:    retire = is_sw && mem.mem_ack;
            S_WB:     retire = 1'b1;
            default:  retire = 1'b0;
         endcase
      end
   end

   assign pc     = pc_q;
   assign state  = state_q;
   assign halted = (state_q == S_HALT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= 32'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         alu_q   <= 32'd0;
         mdr_q   <= 32'd0;
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= 32'd0;
         end
      end else if (!hold) begin
         case (state_q)
            S_FETCH: begin
               if (mem.mem_ack) begin
                  ir_q    <= mem.mem_rdata;
                  pc_q    <= pc_q + 32'd4;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q <= rs_val;
               b_q <= rt_val;
               if (legal)                state_q <= S_EXEC;
               else if (TRAP_ON_ILLEGAL) state_q <= S_HALT;
               else                      state_q <= S_FETCH;
            end
            S_EXEC: begin
               if (is_lw || is_sw) begin
                  alu_q   <= alu_d;
                  state_q <= S_MEM;
               end else if (is_beq) begin
                  if (a_q == b_q) pc_q <= br_pc_d;
                  state_q <= S_FETCH;
               end else if (is_j) begin
                  pc_q    <= jmp_pc_d;
                  state_q <= S_FETCH;
               end else begin
                  alu_q   <= alu_d;
                  state_q <= S_WB;
               end
            end
            S_MEM: begin
               if (mem.mem_ack) begin
                  if (is_sw) begin
                     state_q <= S_FETCH;
                  end else begin
                     mdr_q   <= mem.mem_rdata;
                     state_q <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (wb_dst_d != 5'd0) rf_q[wb_dst_d] <= wb_dat_d;
               state_q <= S_FETCH;
            end
            S_HALT:  state_q <= S_HALT;
            default: state_q <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed programs, write scoreboard, protocol and timing checks.
module tb_mips_multicycle_core;

   logic        clk;
   logic        reset;
   logic        hold;
   logic        hold2;
   logic [31:0] pc, pc2;
   logic [2:0]  state, state2;
   logic        halted, halted2;
   logic        retire, retire2;

   mips_multicycle_core_if bus ();
   mips_multicycle_core_if bus2 ();

   mips_multicycle_core #(.RESET_PC(32'h100), .TRAP_ON_ILLEGAL(1'b1)) dut (
      .clk(clk), .reset(reset), .hold(hold), .mem(bus.master),
      .pc(pc), .state(state), .halted(halted), .retire(retire)
   );

   mips_multicycle_core #(.RESET_PC(32'h100), .TRAP_ON_ILLEGAL(1'b0)) dut2 (
      .clk(clk), .reset(reset), .hold(hold2), .mem(bus2.master),
      .pc(pc2), .state(state2), .halted(halted2), .retire(retire2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: configurable wait states, loads from the bench through a side port.
   logic [31:0] mem [0:255];
   int          wcnt;
   int          wait_n;
   logic        ld_en;
   logic [7:0]  ld_a;
   logic [31:0] ld_d;

   assign bus.mem_ack   = bus.mem_req && (wcnt == wait_n);
   assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
   assign bus2.mem_ack   = bus2.mem_req;
   assign bus2.mem_rdata = 32'hFC00_0000;

   always @(posedge clk) begin
      if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
      else                             wcnt <= 0;
      if (ld_en) mem[ld_a] <= ld_d;
      else if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
   end

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_chk;
   int  n_fail;
   int  ret_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: counts retires and pops the expected-write queue on every completed store.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (retire) ret_cnt++;
            if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_write: addr %h data %h, none expected", bus.mem_addr, bus.mem_wdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("write_addr", bus.mem_addr, e.addr);
                  chk("write_data", bus.mem_wdata, e.data);
               end
            end
         end
      end
   end

   function automatic logic [31:0] enc_r(input int s, input int t, input int d, input logic [5:0] fn);
      enc_r = {6'b000000, 5'(s), 5'(t), 5'(d), 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] o, input int s, input int t, input logic [15:0] imm);
      enc_i = {o, 5'(s), 5'(t), imm};
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic load(input int widx, input logic [31:0] d);
      ld_en = 1'b1;
      ld_a  = 8'(widx);
      ld_d  = d;
      @(posedge clk);
      #1;
      ld_en = 1'b0;
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_ret(input int base, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (ret_cnt > base) break;
         step();
      end
      chk(name, 32'(ret_cnt > base), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int found;
      n_chk   = 0;
      n_fail  = 0;
      ret_cnt = 0;
      wcnt    = 0;
      wait_n  = 0;
      ld_en   = 1'b0;
      ld_a    = 8'd0;
      ld_d    = 32'd0;
      hold    = 1'b0;
      hold2   = 1'b0;
      reset   = 1'b1;

      // ---- Program A: ALU ops, store/load with waits, beq not taken, j back to start
      step();
      load(8'h40, enc_i(6'b001000, 0, 1, 16'd5));
      load(8'h41, enc_i(6'b001000, 0, 2, 16'hFFFD));
      load(8'h42, enc_r(1, 2, 3, 6'b100000));
      load(8'h43, enc_r(2, 1, 4, 6'b101010));
      load(8'h44, enc_i(6'b101011, 0, 3, 16'd8));
      load(8'h45, enc_i(6'b100011, 0, 5, 16'd8));
      load(8'h46, enc_i(6'b101011, 0, 5, 16'd12));
      load(8'h47, enc_r(1, 2, 9, 6'b101010));
      load(8'h48, enc_r(1, 2, 6, 6'b100010));
      load(8'h49, enc_r(1, 2, 7, 6'b100100));
      load(8'h4A, enc_r(1, 2, 8, 6'b100101));
      load(8'h4B, enc_i(6'b001000, 0, 0, 16'd7));
      load(8'h4C, enc_i(6'b101011, 0, 4, 16'd16));
      load(8'h4D, enc_i(6'b101011, 0, 9, 16'd20));
      load(8'h4E, enc_i(6'b101011, 0, 6, 16'd24));
      load(8'h4F, enc_i(6'b101011, 0, 7, 16'd28));
      load(8'h50, enc_i(6'b101011, 0, 8, 16'd32));
      load(8'h51, enc_i(6'b101011, 0, 0, 16'd36));
      load(8'h52, enc_i(6'b000100, 1, 2, 16'd5));
      load(8'h53, {6'b000010, 26'h40});
      load(8'h02, 32'hDEAD_BEEF);
      push_wr(32'd8,  32'd2);
      push_wr(32'd12, 32'd2);
      push_wr(32'd16, 32'd1);
      push_wr(32'd20, 32'd0);
      push_wr(32'd24, 32'd8);
      push_wr(32'd28, 32'd5);
      push_wr(32'd32, 32'hFFFF_FFFD);
      push_wr(32'd36, 32'd0);
      step();
      step();
      chk("reset_pc", pc, 32'h100);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_req", 32'(bus.mem_req), 32'd0);
      chk("reset_addr", bus.mem_addr, 32'd0);
      chk("reset_retire", 32'(retire), 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);

      reset = 1'b0;
      base  = ret_cnt;
      #1;
      chk("first_fetch_req", 32'(bus.mem_req), 32'd1);
      chk("first_fetch_addr", bus.mem_addr, 32'h100);
      repeat (15) step();
      chk("retires_in_16_cycles", 32'(ret_cnt - base), 32'd4);

      wait_n = 3;
      found  = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (bus.mem_req && bus.mem_we) begin
            found = 1;
            break;
         end
      end
      chk("sw_reached_mem", 32'(found), 32'd1);
      chk("sw_addr_first", bus.mem_addr, 32'd8);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("sw_addr_stable", bus.mem_addr, 32'd8);
         chk("sw_we_stable", 32'(bus.mem_we), 32'd1);
      end

      for (int i = 0; i < 2000; i++) begin
         if (ret_cnt >= base + 20) break;
         step();
      end
      chk("program_a_retires", 32'(ret_cnt - base), 32'd20);
      step();
      chk("jump_pc", pc, 32'h100);
      chk("jump_state", 32'(state), 32'd0);
      chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

      // ---- Program B: beq self-loop, then hold during a fetch
      reset  = 1'b1;
      wait_n = 0;
      step();
      load(8'h40, enc_i(6'b000100, 1, 1, 16'hFFFF));
      step();
      step();
      reset = 1'b0;
      #1;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) step();
         chk("beq_retire", 32'(retire), 32'((k % 3) == 2));
         chk("beq_pc", pc, ((k % 3) == 0) ? 32'h100 : 32'h104);
      end
      wait_n = 2;
      step();
      chk("pre_hold_state", 32'(state), 32'd0);
      chk("pre_hold_addr", bus.mem_addr, 32'h100);
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_req", 32'(bus.mem_req), 32'd0);
         chk("hold_state", 32'(state), 32'd0);
         chk("hold_pc", pc, 32'h100);
      end
      hold = 1'b0;
      #1;
      chk("resume_req", 32'(bus.mem_req), 32'd1);
      chk("resume_addr", bus.mem_addr, 32'h100);
      base = ret_cnt;
      wait_ret(base, 20, "retire_after_hold");

      // ---- Program C: reset during a lw wait leaves no side effect
      reset  = 1'b1;
      wait_n = 3;
      step();
      load(8'h00, 32'hABCD_1234);
      load(8'h40, enc_i(6'b100011, 0, 5, 16'd0));
      load(8'h41, enc_i(6'b000100, 0, 0, 16'hFFFF));
      step();
      step();
      reset = 1'b0;
      found = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus.mem_req && !bus.mem_we && (bus.mem_addr == 32'd0)) begin
            found = 1;
            break;
         end
      end
      chk("lw_reached_mem", 32'(found), 32'd1);
      step();
      reset = 1'b1;
      #1;
      chk("abandon_req", 32'(bus.mem_req), 32'd0);
      chk("abandon_retire", 32'(retire), 32'd0);
      load(8'h40, enc_i(6'b101011, 0, 5, 16'd4));
      push_wr(32'd4, 32'd0);
      step();
      step();
      chk("abandon_pc", pc, 32'h100);
      reset = 1'b0;
      base  = ret_cnt;
      wait_ret(base, 60, "retire_after_abandon");
      chk("r5_write_seen", 32'(exp_q.size()), 32'd0);

      // ---- Illegal opcode: trapping core halts, non-trapping core retires it as a NOP
      reset  = 1'b1;
      wait_n = 0;
      step();
      load(8'h40, 32'hFC00_0000);
      step();
      step();
      reset = 1'b0;
      #1;
      chk("nop_core_fetch_state", 32'(state2), 32'd0);
      chk("nop_core_fetch_retire", 32'(retire2), 32'd0);
      step();
      chk("nop_core_retire", 32'(retire2), 32'd1);
      chk("nop_core_pc", pc2, 32'h104);
      step();
      chk("nop_core_back_to_fetch", 32'(state2), 32'd0);
      chk("trap_halted", 32'(halted), 32'd1);
      chk("trap_state", 32'(state), 32'd5);
      chk("trap_req", 32'(bus.mem_req), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("halt_stays", 32'(state), 32'd5);
         chk("halt_no_retire", 32'(retire), 32'd0);
         chk("halt_no_req", 32'(bus.mem_req), 32'd0);
      end
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
